fsab_arb: RTL and testbench

FSAB_ARB -- requirements
Module: fsab_arb

---
 rtl/fsab_arb.sv | 274 +++++++++++++++++++++++++++
 tb/tb_fsab_arb.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsab_arb.sv
// fsab_arb: merges ICache and DCache FSAB request streams onto one credited downstream port.
// Define FSAB_ARB_DC_PRIO_EN for strict DCache priority; the default is round-robin.

`ifndef FSAB_READ
`define FSAB_READ 1'b0
`endif
`ifndef FSAB_WRITE
`define FSAB_WRITE 1'b1
`endif
`ifndef FSAB_DID_HI
`define FSAB_DID_HI 3
`endif
`ifndef FSAB_SUBDID_HI
`define FSAB_SUBDID_HI 3
`endif
`ifndef FSAB_ADDR_HI
`define FSAB_ADDR_HI 30
`endif
`ifndef FSAB_LEN_HI
`define FSAB_LEN_HI 2
`endif
`ifndef FSAB_DATA_HI
`define FSAB_DATA_HI 63
`endif
`ifndef FSAB_MASK_HI
`define FSAB_MASK_HI 7
`endif
`ifndef FSAB_INITIAL_CREDITS
`define FSAB_INITIAL_CREDITS 4
`endif

module fsab_arb_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic         o_empty,
  output logic         o_ovf
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [CW-1:0] r_cnt;
  logic          w_full;
  logic          w_do_pop;
  logic          w_do_push;

  assign o_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == CW'(DEPTH));
  assign w_do_pop  = i_pop && !o_empty;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign w_do_push = i_push && (!w_full || w_do_pop);
  assign o_head    = r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
      o_ovf <= 1'b0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: ;
      endcase
      if (i_push && !w_do_push) o_ovf <= 1'b1;
    end
  end
endmodule

module fsab_arb #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned DOWN_CREDITS = `FSAB_INITIAL_CREDITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ic_fsabo_valid,
  input  logic                    ic_fsabo_mode,
  input  logic [`FSAB_DID_HI:0]   ic_fsabo_did,
  input  logic [`FSAB_SUBDID_HI:0] ic_fsabo_subdid,
  input  logic [`FSAB_ADDR_HI:0]  ic_fsabo_addr,
  input  logic [`FSAB_LEN_HI:0]   ic_fsabo_len,
  input  logic [`FSAB_DATA_HI:0]  ic_fsabo_data,
  input  logic [`FSAB_MASK_HI:0]  ic_fsabo_mask,
  output logic                    ic_fsabo_credit,
  input  logic                    dc_fsabo_valid,
  input  logic                    dc_fsabo_mode,
  input  logic [`FSAB_DID_HI:0]   dc_fsabo_did,
  input  logic [`FSAB_SUBDID_HI:0] dc_fsabo_subdid,
  input  logic [`FSAB_ADDR_HI:0]  dc_fsabo_addr,
  input  logic [`FSAB_LEN_HI:0]   dc_fsabo_len,
  input  logic [`FSAB_DATA_HI:0]  dc_fsabo_data,
  input  logic [`FSAB_MASK_HI:0]  dc_fsabo_mask,
  output logic                    dc_fsabo_credit,
  output logic                    fsabo_valid,
  output logic                    fsabo_mode,
  output logic [`FSAB_DID_HI:0]   fsabo_did,
  output logic [`FSAB_SUBDID_HI:0] fsabo_subdid,
  output logic [`FSAB_ADDR_HI:0]  fsabo_addr,
  output logic [`FSAB_LEN_HI:0]   fsabo_len,
  output logic [`FSAB_DATA_HI:0]  fsabo_data,
  output logic [`FSAB_MASK_HI:0]  fsabo_mask,
  input  logic                    fsabo_credit,
  output logic [1:0]              ovf
);
  localparam int unsigned LEN_W = `FSAB_LEN_HI + 1;
  localparam int unsigned CRW   = $clog2(DOWN_CREDITS + 1);

  typedef struct packed {
    logic                     mode;
    logic [`FSAB_DID_HI:0]    did;
    logic [`FSAB_SUBDID_HI:0] subdid;
    logic [`FSAB_ADDR_HI:0]   addr;
    logic [`FSAB_LEN_HI:0]    len;
    logic [`FSAB_DATA_HI:0]   data;
    logic [`FSAB_MASK_HI:0]   mask;
  } beat_t;

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t         r_state;
  logic           r_grant;
  logic [LEN_W-1:0] r_remain;
  logic [CRW-1:0] r_credits;

  beat_t w_ic_in;
  beat_t w_dc_in;
  beat_t w_ic_head;
  beat_t w_dc_head;
  beat_t w_head;
  logic  w_ic_empty;
  logic  w_dc_empty;
  logic  w_ic_ovf;
  logic  w_dc_ovf;
  logic  w_cred_ok;
  logic  w_pick_dc;
  logic  w_pop_ic;
  logic  w_pop_dc;
  logic  w_pop;
  logic  w_multi;

  assign w_ic_in = '{mode: ic_fsabo_mode, did: ic_fsabo_did, subdid: ic_fsabo_subdid,
                     addr: ic_fsabo_addr, len: ic_fsabo_len, data: ic_fsabo_data,
                     mask: ic_fsabo_mask};
  assign w_dc_in = '{mode: dc_fsabo_mode, did: dc_fsabo_did, subdid: dc_fsabo_subdid,
                     addr: dc_fsabo_addr, len: dc_fsabo_len, data: dc_fsabo_data,
                     mask: dc_fsabo_mask};

  fsab_arb_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(beat_t))) u_ic_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (ic_fsabo_valid),
    .i_data  (w_ic_in),
    .i_pop   (w_pop_ic),
    .o_head  (w_ic_head),
    .o_empty (w_ic_empty),
    .o_ovf   (w_ic_ovf)
  );

  fsab_arb_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(beat_t))) u_dc_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (dc_fsabo_valid),
    .i_data  (w_dc_in),
    .i_pop   (w_pop_dc),
    .o_head  (w_dc_head),
    .o_empty (w_dc_empty),
    .o_ovf   (w_dc_ovf)
  );

  assign ovf       = {w_dc_ovf, w_ic_ovf};
  assign w_cred_ok = (r_credits != '0);

  always_comb begin
    w_pick_dc = 1'b0;
    w_pop_ic  = 1'b0;
    w_pop_dc  = 1'b0;
`ifdef FSAB_ARB_DC_PRIO_EN
    w_pick_dc = !w_dc_empty;
`else
    // r_grant holds the last winner, so the other client wins a tie.
    if (!w_ic_empty && !w_dc_empty) w_pick_dc = !r_grant;
    else                            w_pick_dc = !w_dc_empty;
`endif
    if (w_cred_ok) begin
      if (r_state == S_IDLE) begin
        if (!w_ic_empty || !w_dc_empty) begin
          w_pop_dc = w_pick_dc;
          w_pop_ic = !w_pick_dc;
        end
      end else if (r_grant) begin
        w_pop_dc = !w_dc_empty;
      end else begin
        w_pop_ic = !w_ic_empty;
      end
    end
  end

  assign w_pop   = w_pop_ic || w_pop_dc;
  assign w_head  = w_pop_dc ? w_dc_head : w_ic_head;
  assign w_multi = (w_head.mode == `FSAB_WRITE) && (w_head.len > LEN_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_grant         <= 1'b1;
      r_remain        <= '0;
      r_credits       <= CRW'(DOWN_CREDITS);
      fsabo_valid     <= 1'b0;
      fsabo_mode      <= '0;
      fsabo_did       <= '0;
      fsabo_subdid    <= '0;
      fsabo_addr      <= '0;
      fsabo_len       <= '0;
      fsabo_data      <= '0;
      fsabo_mask      <= '0;
      ic_fsabo_credit <= 1'b0;
      dc_fsabo_credit <= 1'b0;
    end else begin
      fsabo_valid     <= w_pop;
      ic_fsabo_credit <= w_pop_ic;
      dc_fsabo_credit <= w_pop_dc;
      if (w_pop) begin
        fsabo_mode   <= w_head.mode;
        fsabo_did    <= w_head.did;
        fsabo_subdid <= w_head.subdid;
        fsabo_addr   <= w_head.addr;
        fsabo_len    <= w_head.len;
        fsabo_data   <= w_head.data;
        fsabo_mask   <= w_head.mask;
      end

      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_grant <= w_pop_dc;
            if (w_multi) begin
              r_state  <= S_BURST;
              r_remain <= w_head.len - 1'b1;
            end
          end
        end
        S_BURST: begin
          if (w_pop) begin
            r_remain <= r_remain - 1'b1;
            if (r_remain == LEN_W'(1)) r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      case ({w_pop, fsabo_credit})
        2'b10:   r_credits <= r_credits - 1'b1;
        2'b01:   if (r_credits != CRW'(DOWN_CREDITS)) r_credits <= r_credits + 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fsab_arb.sv
// Testbench for fsab_arb: queue-based reference model, packet table, and directed corner sequences.
module tb_fsab_arb;
  localparam int unsigned DEPTH = 4;
  localparam int          DOWN  = 4;
  localparam logic        RD    = 1'b0;
  localparam logic        WR    = 1'b1;

  typedef struct packed {
    logic        mode;
    logic [3:0]  did;
    logic [3:0]  subdid;
    logic [30:0] addr;
    logic [2:0]  len;
    logic [63:0] data;
    logic [7:0]  mask;
  } beat_t;

  typedef struct {
    int          client;
    int          cycle;
    logic [30:0] addr;
    logic [63:0] data;
  } ent_t;

  typedef struct {
    int   c;
    logic mode;
    int   len;
    int   nb;
    bit   oth;
    int   exp_p;
    int   exp_o;
  } vec_t;

  logic  clk = 1'b0;
  logic  rst = 1'b0;
  logic  ic_v = 1'b0;
  logic  dc_v = 1'b0;
  logic  fsabo_credit = 1'b0;
  beat_t ic_in = '0;
  beat_t dc_in = '0;

  logic        fsabo_valid, fsabo_mode, ic_cr, dc_cr;
  logic [3:0]  fsabo_did, fsabo_subdid;
  logic [30:0] fsabo_addr;
  logic [2:0]  fsabo_len;
  logic [63:0] fsabo_data;
  logic [7:0]  fsabo_mask;
  logic [1:0]  ovf;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fsab_arb #(.FIFO_DEPTH(DEPTH), .DOWN_CREDITS(DOWN)) dut (
    .clk             (clk),
    .rst             (rst),
    .ic_fsabo_valid  (ic_v),
    .ic_fsabo_mode   (ic_in.mode),
    .ic_fsabo_did    (ic_in.did),
    .ic_fsabo_subdid (ic_in.subdid),
    .ic_fsabo_addr   (ic_in.addr),
    .ic_fsabo_len    (ic_in.len),
    .ic_fsabo_data   (ic_in.data),
    .ic_fsabo_mask   (ic_in.mask),
    .ic_fsabo_credit (ic_cr),
    .dc_fsabo_valid  (dc_v),
    .dc_fsabo_mode   (dc_in.mode),
    .dc_fsabo_did    (dc_in.did),
    .dc_fsabo_subdid (dc_in.subdid),
    .dc_fsabo_addr   (dc_in.addr),
    .dc_fsabo_len    (dc_in.len),
    .dc_fsabo_data   (dc_in.data),
    .dc_fsabo_mask   (dc_in.mask),
    .dc_fsabo_credit (dc_cr),
    .fsabo_valid     (fsabo_valid),
    .fsabo_mode      (fsabo_mode),
    .fsabo_did       (fsabo_did),
    .fsabo_subdid    (fsabo_subdid),
    .fsabo_addr      (fsabo_addr),
    .fsabo_len       (fsabo_len),
    .fsabo_data      (fsabo_data),
    .fsabo_mask      (fsabo_mask),
    .fsabo_credit    (fsabo_credit),
    .ovf             (ovf)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: per-client beat queues, a packet beat countdown and a credit pool.
  beat_t ic_q[$];
  beat_t dc_q[$];
  int    m_cred = DOWN;
  int    m_left = 0;
  int    m_cur = 0;
  int    m_last = 1;
  int    m_pc;
  logic  m_valid = 1'b0;
  logic  m_icc = 1'b0;
  logic  m_dcc = 1'b0;
  logic [1:0] m_ovf = 2'b00;
  beat_t m_beat = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ic_q.delete();
      dc_q.delete();
      m_cred = DOWN; m_left = 0; m_cur = 0; m_last = 1;
      m_valid = 1'b0; m_icc = 1'b0; m_dcc = 1'b0; m_ovf = 2'b00; m_beat = '0;
    end else begin
      m_pc = -1;
      if (m_cred > 0) begin
        if (m_left == 0) begin
`ifdef FSAB_ARB_DC_PRIO_EN
          if (dc_q.size() > 0)      m_pc = 1;
          else if (ic_q.size() > 0) m_pc = 0;
`else
          if (ic_q.size() > 0 && dc_q.size() > 0) m_pc = 1 - m_last;
          else if (ic_q.size() > 0)               m_pc = 0;
          else if (dc_q.size() > 0)               m_pc = 1;
`endif
        end else if ((m_cur == 0 ? ic_q.size() : dc_q.size()) > 0) begin
          m_pc = m_cur;
        end
      end
      m_valid = (m_pc >= 0);
      m_icc   = (m_pc == 0);
      m_dcc   = (m_pc == 1);
      if (m_pc >= 0) begin
        if (m_pc == 0) m_beat = ic_q.pop_front();
        else           m_beat = dc_q.pop_front();
        if (m_left == 0) begin
          m_cur = m_pc; m_last = m_pc;
          m_left = (m_beat.mode == WR) ? ((m_beat.len == 3'd0) ? 1 : int'(m_beat.len)) : 1;
        end
        m_left--;
      end
      if (m_pc >= 0 && !fsabo_credit)                m_cred--;
      else if (m_pc < 0 && fsabo_credit && m_cred < DOWN) m_cred++;
      if (ic_v) begin
        if (ic_q.size() < DEPTH) ic_q.push_back(ic_in); else m_ovf[0] = 1'b1;
      end
      if (dc_v) begin
        if (dc_q.size() < DEPTH) dc_q.push_back(dc_in); else m_ovf[1] = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en)
      check("model", {fsabo_valid, fsabo_mode, fsabo_did, fsabo_subdid, fsabo_addr, fsabo_len,
                      fsabo_data, fsabo_mask, ic_cr, dc_cr, ovf},
                     {m_valid, m_beat, m_icc, m_dcc, m_ovf});
  end

  ent_t log_q[$];
  ent_t lg;
  always @(posedge clk) begin
    #1;
    if (fsabo_valid) begin
      lg.client = dc_cr ? 1 : (ic_cr ? 0 : -1);
      lg.cycle  = cyc;
      lg.addr   = fsabo_addr;
      lg.data   = fsabo_data;
      log_q.push_back(lg);
    end
  end

  function automatic beat_t mk(input logic m, input int l, input int a, input int d);
    beat_t b;
    b.mode = m; b.did = 4'd1; b.subdid = 4'd2; b.addr = 31'(a);
    b.len = 3'(l); b.data = 64'(d); b.mask = 8'hff;
    return b;
  endfunction

  function automatic beat_t rnd_beat();
    beat_t b;
    b.mode = 1'($urandom_range(0, 1)); b.did = 4'($urandom); b.subdid = 4'($urandom);
    b.addr = 31'($urandom); b.len = 3'($urandom); b.data = {$urandom, $urandom};
    b.mask = 8'($urandom);
    return b;
  endfunction

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    ic_v = 1'b0; dc_v = 1'b0; fsabo_credit = 1'b0;
    #2 rst = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    log_q.delete();
  endtask

  function automatic int count_client(input int c);
    int n = 0;
    foreach (log_q[i]) if (log_q[i].client == c) n++;
    return n;
  endfunction

  vec_t vecs[8];
  bit   found;

  initial begin
    vecs[0] = '{c: 0, mode: RD, len: 0, nb: 1, oth: 1, exp_p: 1, exp_o: 1};
    vecs[1] = '{c: 0, mode: RD, len: 5, nb: 1, oth: 1, exp_p: 1, exp_o: 1};
    vecs[2] = '{c: 1, mode: WR, len: 0, nb: 1, oth: 1, exp_p: 1, exp_o: 1};
    vecs[3] = '{c: 1, mode: WR, len: 1, nb: 1, oth: 1, exp_p: 1, exp_o: 1};
    vecs[4] = '{c: 0, mode: WR, len: 2, nb: 2, oth: 1, exp_p: 2, exp_o: 1};
    vecs[5] = '{c: 1, mode: WR, len: 7, nb: 7, oth: 0, exp_p: 7, exp_o: 0};
    vecs[6] = '{c: 0, mode: WR, len: 3, nb: 2, oth: 1, exp_p: 2, exp_o: 0};
    vecs[7] = '{c: 1, mode: WR, len: 4, nb: 3, oth: 1, exp_p: 3, exp_o: 0};

    // Reset state
    #1 rst = 1'b1;
    step(2);
    check("rst_outputs", {fsabo_valid, ic_cr, dc_cr, ovf, fsabo_addr, fsabo_data}, '0);
    chk_en = 1'b1;
    #2 rst = 1'b0;
    step();

    // Single ic read: valid two edges after the push
    do_reset();
    ic_in = mk(RD, 0, 'h40, 'h11); ic_v = 1'b1;
    step();
    ic_v = 1'b0;
    check("read_lat1_valid", fsabo_valid, 1'b0);
    step();
    check("read_lat2", {fsabo_valid, fsabo_mode, fsabo_addr, ic_cr, dc_cr}, {1'b1, RD, 31'h40, 1'b1, 1'b0});
    step();
    check("read_after", {fsabo_valid, ic_cr}, 2'b00);
    step(4);
    check("read_one_credit", 128'(count_client(0)), 128'(1));

    // Packet table
    foreach (vecs[v]) begin
      do_reset();
      fsabo_credit = 1'b1;
      for (int k = 0; k < ((vecs[v].nb > 2) ? vecs[v].nb : 2); k++) begin
        ic_v = 1'b0; dc_v = 1'b0;
        if (k < vecs[v].nb) begin
          if (vecs[v].c == 0) begin ic_in = mk(vecs[v].mode, vecs[v].len, 'h700 + 4*k, k); ic_v = 1'b1; end
          else                begin dc_in = mk(vecs[v].mode, vecs[v].len, 'h700 + 4*k, k); dc_v = 1'b1; end
        end
        if (k == 1 && vecs[v].oth) begin
          if (vecs[v].c == 0) begin dc_in = mk(RD, 0, 'h800, 99); dc_v = 1'b1; end
          else                begin ic_in = mk(RD, 0, 'h800, 99); ic_v = 1'b1; end
        end
        step();
      end
      ic_v = 1'b0; dc_v = 1'b0;
      step(12);
      fsabo_credit = 1'b0;
      check($sformatf("vec%0d_primary", v), 128'(count_client(vecs[v].c)), 128'(vecs[v].exp_p));
      check($sformatf("vec%0d_other", v), 128'(count_client(1 - vecs[v].c)), 128'(vecs[v].exp_o));
      if (log_q.size() > 0) check($sformatf("vec%0d_first_addr", v), log_q[0].addr, 31'h700);
    end

    // dc write burst is not interleaved with ic reads
    do_reset();
    fsabo_credit = 1'b1;
    dc_in = mk(WR, 3, 'h100, 0); dc_v = 1'b1;
    step();
    for (int k = 1; k <= 3; k++) begin
      dc_v = (k < 3);
      dc_in = mk(WR, 3, 'h100, k);
      ic_in = mk(RD, 0, 'h200 + 4*(k-1), 50 + k); ic_v = 1'b1;
      step();
    end
    ic_v = 1'b0; dc_v = 1'b0;
    step(8);
    fsabo_credit = 1'b0;
    check("burst_count", 128'(log_q.size()), 128'(6));
    if (log_q.size() == 6) begin
      for (int i = 0; i < 6; i++) check($sformatf("burst_client%0d", i), 128'(log_q[i].client), (i < 3) ? 128'(1) : 128'(0));
      for (int i = 0; i < 3; i++) check($sformatf("burst_data%0d", i), log_q[i].data, 64'(i));
      check("burst_consecutive", 128'(log_q[2].cycle - log_q[0].cycle), 128'(2));
      check("ic_after_burst_addr", log_q[3].addr, 31'h200);
    end

    // Two reads per client queued together
    do_reset();
    for (int k = 0; k < 2; k++) begin
      ic_in = mk(RD, 0, 'h10 + 4*k, k); ic_v = 1'b1;
      dc_in = mk(RD, 0, 'h20 + 4*k, k); dc_v = 1'b1;
      step();
    end
    ic_v = 1'b0; dc_v = 1'b0;
    step(8);
    check("order_count", 128'(log_q.size()), 128'(4));
    if (log_q.size() == 4) begin
`ifdef FSAB_ARB_DC_PRIO_EN
      check("order0", log_q[0].addr, 31'h20);
      check("order1", log_q[1].addr, 31'h24);
      check("order2", log_q[2].addr, 31'h10);
      check("order3", log_q[3].addr, 31'h14);
`else
      check("order0", log_q[0].addr, 31'h10);
      check("order1", log_q[1].addr, 31'h20);
      check("order2", log_q[2].addr, 31'h14);
      check("order3", log_q[3].addr, 31'h24);
`endif
    end

    // Credit exhaustion stalls, one returned credit gives one launch
    do_reset();
    for (int k = 0; k < 4; k++) begin
      ic_in = mk(RD, 0, 'h300 + 4*k, k); ic_v = 1'b1;
      dc_in = mk(RD, 0, 'h380 + 4*k, k); dc_v = (k < 2);
      step();
    end
    ic_v = 1'b0; dc_v = 1'b0;
    step(12);
    check("stall_launches", 128'(log_q.size()), 128'(DOWN));
    fsabo_credit = 1'b1;
    step();
    fsabo_credit = 1'b0;
    step(6);
    check("one_credit_launch", 128'(log_q.size()), 128'(DOWN + 1));

    // Overflow on 5th push with no credits
    do_reset();
    for (int k = 0; k < DOWN; k++) begin
      ic_in = mk(RD, 0, 'h400 + 4*k, k); ic_v = 1'b1;
      step();
    end
    ic_v = 1'b0;
    step(6);
    log_q.delete();
    for (int k = 0; k < 5; k++) begin
      ic_in = mk(RD, 0, 'h500 + 4*k, k); ic_v = 1'b1;
      step();
      if (k == 3) check("ovf_after_4", ovf, 2'b00);
      if (k == 4) check("ovf_after_5", ovf, 2'b01);
    end
    ic_v = 1'b0;
    check("ovf_no_launch", 128'(log_q.size()), 128'(0));
    fsabo_credit = 1'b1;
    step(10);
    fsabo_credit = 1'b0;
    check("ovf_kept_count", 128'(log_q.size()), 128'(4));
    if (log_q.size() == 4)
      for (int i = 0; i < 4; i++) check($sformatf("ovf_kept%0d", i), log_q[i].addr, 31'(32'h500 + 4*i));
    check("ovf_sticky", ovf, 2'b01);

    // Reset in the middle of a write burst
    do_reset();
    fsabo_credit = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ic_in = mk(WR, 4, 'h600 + 4*k, k); ic_v = 1'b1;
      step();
      if (fsabo_valid && fsabo_data == 64'd1) begin found = 1'b1; break; end
    end
    check("burst_beat2_seen", found, 1'b1);
    ic_v = 1'b0; fsabo_credit = 1'b0;
    #2 rst = 1'b1;
    #1 check("rst_async", {fsabo_valid, ic_cr, dc_cr, ovf, fsabo_addr}, '0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    log_q.delete();
    step(6);
    check("rst_no_stray", 128'(log_q.size()), 128'(0));
    for (int k = 0; k < DOWN + 1; k++) begin
      ic_in = mk(RD, 0, 'h680 + 4*k, k); ic_v = 1'b1;
      step();
    end
    ic_v = 1'b0;
    step(8);
    check("rst_credits_restored", 128'(log_q.size()), 128'(DOWN));

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      ic_v = ($urandom_range(0, 9) < 4);
      dc_v = ($urandom_range(0, 9) < 4);
      ic_in = rnd_beat();
      dc_in = rnd_beat();
      fsabo_credit = ($urandom_range(0, 1) == 1);
      if (n == 1500) begin
        ic_v = 1'b0; dc_v = 1'b0;
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
      end
      step();
    end
    ic_v = 1'b0; dc_v = 1'b0; fsabo_credit = 1'b1;
    step(40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
